// File: rtl/add8_seq_ctrl.sv
// add8_seq_ctrl: runs a wide add one byte slice at a time through a shared 8-bit adder.
// Define ADD_SUB_EN to make op=1 compute A-B; without it op is ignored.
module add8_seq_ctrl #(
  parameter int SLICES = 4,
  parameter int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*SLICES-1:0] op_a,
  input  logic [8*SLICES-1:0] op_b,
  input  logic                cin,
  input  logic                op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*SLICES-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic                ovf,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout
);
  localparam int W = 8 * SLICES;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, b_eff, res_nxt;
  logic [IDXW-1:0] idx;
  logic carry, c_eff, last, run;
`ifdef ADD_SUB_EN
  // Subtraction is A + ~B + 1, so the incoming carry is forced high.
  assign b_eff = op ? ~op_b : op_b;
  assign c_eff = op | cin;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_eff = op_b;
  assign c_eff = cin;
`endif
  assign run = state == RUN;
  assign last = idx == IDXW'(SLICES - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign add_a = run ? a_r[8*idx +: 8] : 8'd0;
  assign add_b = run ? b_r[8*idx +: 8] : 8'd0;
  assign add_cin = run ? carry : 1'b0;
  always_comb begin
    res_nxt = result;
    res_nxt[8*idx +: 8] = add_sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= op_a;
          b_r <= b_eff;
          carry <= c_eff;
          result <= '0;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          result <= res_nxt;
          carry <= add_cout;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout <= add_cout;
            zero <= res_nxt == '0;
            ovf <= (a_r[W-1] == b_r[W-1]) && (add_sum[7] != a_r[W-1]);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add8_seq_ctrl.sv
// tb_add8_seq_ctrl: directed checks of add8_seq_ctrl with a behavioural 8-bit adder attached.
module tb_add8_seq_ctrl;
  logic clk = 0, rst = 0, in_valid = 0, cin = 0, op = 0, out_ready = 1;
  logic [31:0] op_a = 0, op_b = 0;
  logic in_ready, out_valid, cout, zero, ovf, add_cin, add_cout;
  logic [31:0] result;
  logic [7:0] add_a, add_b, add_sum;
  int checks = 0, failures = 0;
  int lat;
  logic cin_log [0:31];

  add8_seq_ctrl #(.SLICES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  // Issues one request and returns at the negedge where out_valid is first seen.
  task automatic do_request(input logic [31:0] a, input logic [31:0] b, input logic c, input logic o);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; op = o; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 20) break;
      cin_log[lat] = add_cin;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({result, cout, zero, ovf} !== 35'd0) begin failures++; $display("FAIL reset_outputs got=%h/%b%b%b exp=0", result, cout, zero, ovf); end
    checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin failures++; $display("FAIL reset_adder_quiet got=%h %h %b exp=0", add_a, add_b, add_cin); end
  endtask

  task automatic test_basic_add;
    do_request(32'h10, 32'h10, 0, 0);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (result !== 32'h20) begin failures++; $display("FAIL basic_result got=%h exp=00000020", result); end
    checks++; if ({cout, zero, ovf} !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", {cout, zero, ovf}); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL basic_release got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_carry_chain;
    do_request(32'hFFFFFFFF, 32'h1, 0, 0);
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL wrap_result got=%h exp=00000000", result); end
    checks++; if ({cout, zero, ovf} !== 3'b110) begin failures++; $display("FAIL wrap_flags got=%b exp=110", {cout, zero, ovf}); end
    checks++;
    if (lat < 4) begin failures++; $display("FAIL wrap_cin_chain got=lat%0d exp=lat4", lat); end
    else if ({cin_log[0], cin_log[1], cin_log[2], cin_log[3]} !== 4'b0111) begin
      failures++; $display("FAIL wrap_cin_chain got=%b exp=0111", {cin_log[0], cin_log[1], cin_log[2], cin_log[3]});
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    do_request(32'h7FFFFFFF, 32'h1, 0, 0);
    checks++; if (result !== 32'h80000000) begin failures++; $display("FAIL ovf_result got=%h exp=80000000", result); end
    checks++; if ({cout, zero, ovf} !== 3'b001) begin failures++; $display("FAIL ovf_flags got=%b exp=001", {cout, zero, ovf}); end
    @(negedge clk);
    do_request(32'h64, 32'h32, 1, 0);
    checks++; if (result !== 32'h97) begin failures++; $display("FAIL cin_result got=%h exp=00000097", result); end
    checks++; if ({cout, zero, ovf} !== 3'b000) begin failures++; $display("FAIL cin_flags got=%b exp=000", {cout, zero, ovf}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 0;
    do_request(32'h11111111, 32'h22222222, 0, 0);
    for (int i = 0; i < 3; i++) begin
      op_a = 32'hDEAD0000 + i; op_b = 32'h1; in_valid = 1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || result !== 32'h33333333) begin
        failures++; $display("FAIL hold_%0d got=%b%b %h exp=10 33333333", i, out_valid, in_ready, result);
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready}); end
    checks++; if (result !== 32'h33333333) begin failures++; $display("FAIL idle_keeps_result got=%h exp=33333333", result); end
  endtask

  task automatic test_reset_in_run;
    @(negedge clk);
    op_a = 32'h01020304; op_b = 32'h10203040; cin = 0; op = 0; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    checks++; if ({add_a, add_b} !== 16'h0220) begin failures++; $display("FAIL run_idx2_operands got=%h %h exp=02 20", add_a, add_b); end
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL abort_handshake got=%b exp=10", {in_ready, out_valid}); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", result); end
    checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin failures++; $display("FAIL abort_adder got=%h %h %b exp=0", add_a, add_b, add_cin); end
    repeat (6) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_subtract;
    do_request(32'h5, 32'h7, 0, 1);
`ifdef ADD_SUB_EN
    checks++; if (result !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_result got=%h exp=FFFFFFFE", result); end
`else
    checks++; if (result !== 32'hC) begin failures++; $display("FAIL sub_result got=%h exp=0000000C", result); end
`endif
    checks++; if ({cout, zero, ovf} !== 3'b000) begin failures++; $display("FAIL sub_flags got=%b exp=000", {cout, zero, ovf}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_request(32'h000000FF, 32'h00000001, 0, 0);
    checks++; if (result !== 32'h100) begin failures++; $display("FAIL b2b_first got=%h exp=00000100", result); end
    do_request(32'h80000000, 32'h80000000, 0, 0);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if ({result, cout, zero, ovf} !== {32'h0, 3'b111}) begin failures++; $display("FAIL b2b_second got=%h %b exp=00000000 111", result, {cout, zero, ovf}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_carry_chain;
    test_overflow;
    test_backpressure;
    test_reset_in_run;
    test_subtract;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
